muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle integer multiply/divide unit beside the EX-stage ALU, for MULT/MULTU/DIV/DIVU.
//  Accepts one operation on start and iterates a 33-bit add/sub step once per cycle.
//  Raises busy so the hazard unit stalls MFHI/MFLO, then pulses done with HI/LO results.
// PARAMETERS
//  WIDTH      32  operand width; HI/LO are WIDTH each
//  CNT_W       6  iteration counter width; must hold WIDTH
// PORTS
//  clk     in   1      single clock, rising edge
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled only in IDLE
//  op      in   2      0=MULT 1=MULTU 2=DIV 3=DIVU (muldiv_pkg)
//  a       in   WIDTH  multiplicand / dividend (rs)
//  b       in   WIDTH  multiplier / divisor (rt)
//  busy    out  1      high in PREP, ITER, FIX
//  done    out  1      one-cycle pulse; hi/lo valid from this cycle on
//  hi      out  WIDTH  product[63:32] / remainder
//  lo      out  WIDTH  product[31:0] / quotient
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy=0; done=0; hi=0; lo=0; counter=0.
//  FSM: IDLE -start-> PREP -> ITER(xWIDTH) -> FIX -> DONE -> IDLE.
//   PREP: latch op. For signed ops, take |a| and |b|; record neg_res = sign(a)^sign(b) and neg_rem = sign(a).
//         If op is DIV/DIVU and b==0, go directly to DONE.
//   ITER, multiply: if mplier[0]=1, acc33 += mcand; then {acc,mplier} >>= 1.
//   ITER, divide (restoring): shift {rem,quot} left by 1; trial = rem33 - divisor;
//         if no borrow, rem=trial and quot[0]=1.
//   ITER runs exactly WIDTH cycles; leave ITER when the counter reaches WIDTH-1.
//   FIX: MULT with neg_res negates the 64-bit product.
//        DIV with neg_res negates the quotient; DIV with neg_rem negates the remainder.
//        Load hi/lo.
//   DONE: done=1 for one cycle; busy=0; return to IDLE.
//  Latency (start high in cycle T): PREP T+1, ITER T+2..T+33, FIX T+34, done in T+35.
//  Divide by zero: done in T+2 with hi=a (unmodified), lo={WIDTH{1}}; no exception raised.
//  Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0; falls out of the abs/negate path.
//  start while busy or done is high: ignored, no queueing.
//  hi/lo hold their last result until the next FIX or DONE, or until reset.
//  Operands are captured in PREP; a/b changes after the start cycle have no effect.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: for MULT/MULTU, if |b|[WIDTH-1:WIDTH/2]==0 at PREP, ITER runs WIDTH/2 cycles.
//   FIX then right-shifts {acc,mplier} by WIDTH/2 before the sign fix, so done arrives in T+19.
//  Undefined: fixed WIDTH iterations for every op; early-out logic is absent.
//  Division latency is the same in both builds.
// STRUCTURE
//  muldiv_pkg:
//   - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU
//   - FSM state typedef (IDLE, PREP, ITER, FIX, DONE)
//   - ALU_ADD=3'd0 and ALU_SUB=3'd1, shared with the EX-stage decoder
//  Sub-module muldiv_step: combinational 33-bit add/sub plus shift, selected by the mul/div flag.
//   The FSM, counter and registers stay in muldiv_sequencer.
// TESTING
//  1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; done exactly in T+35; busy high T+1..T+34.
//  2 MULT a=-3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; with MULDIV_EARLY_OUT_EN, done in T+19.
//  3 DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3) hi=0xFFFFFFFF (-1); DIVU a=7 b=2 -> lo=3 hi=1.
//  4 DIVU a=5 b=0 -> done in T+2, hi=5 lo=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
//  5 start pulsed at T+5 during a busy op -> ignored; result and done timing match the first op only.
//  6 rst_n low at T+10 (mid-ITER) -> busy=done=hi=lo=0 immediately;
//    after release, MULTU 6*7 -> lo=42 hi=0 in full latency.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// op encodings, FSM state constants and the add/sub selector codes
// that the EX-stage decoder also uses.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_PREP = 3'd1;
    localparam state_t S_ITER = 3'd2;
    localparam state_t S_FIX  = 3'd3;
    localparam state_t S_DONE = 3'd4;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier / restoring divider.
// Multiply: {acc, mplier} gets acc+mcand (when mplier[0]) then shifts right.
// Divide:   {rem, quot} shifts left, the divisor is trial-subtracted, and
//           the quotient bit is set when the subtraction does not borrow.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] work_i,
    input  logic [WIDTH-1:0] oper_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] work_o
);
    import muldiv_pkg::*;

    logic [2:0]     aluOp;
    logic [WIDTH:0]   lhs;
    logic [WIDTH:0]   rhs;
    logic [WIDTH+1:0] res;

    // Shared 33-bit adder/subtractor; the extra top bit exposes the borrow
    always_comb begin
        aluOp = div_i ? ALU_SUB : ALU_ADD;
        lhs   = div_i ? {acc_i, work_i[WIDTH-1]} : {1'b0, acc_i};
        rhs   = (div_i || work_i[0]) ? {1'b0, oper_i} : '0;
        if (aluOp == ALU_SUB) begin
            res = {1'b0, lhs} - {1'b0, rhs};
        end else begin
            res = {1'b0, lhs} + {1'b0, rhs};
        end
        if (div_i) begin
            acc_o  = res[WIDTH+1] ? lhs[WIDTH-1:0] : res[WIDTH-1:0];
            work_o = {work_i[WIDTH-2:0], ~res[WIDTH+1]};
        end else begin
            acc_o  = res[WIDTH:1];
            work_o = {res[0], work_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the EX-stage ALU.
// Operands are captured on the accepted start, made non-negative in PREP,
// iterated through muldiv_step, and sign-corrected in FIX.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies whose |b| fits in the
// low half of the word finish after WIDTH/2 iterations.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] oper_q, oper_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
`ifdef MULDIV_EARLY_OUT_EN
    logic             early_q, early_d;
`endif

    logic             isDiv;
    logic             isSigned;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [CNT_W-1:0] lastCnt;
    logic [WIDTH-1:0] stepAcc;
    logic [WIDTH-1:0] stepWork;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prodFixed;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_i  (isDiv),
        .acc_i  (acc_q),
        .work_i (work_q),
        .oper_i (oper_q),
        .acc_o  (stepAcc),
        .work_o (stepWork)
    );

    // Operand magnitudes, iteration bound and sign-corrected multiply result
    always_comb begin
        isDiv    = op_q[1];
        isSigned = ~op_q[0];
        absA     = (isSigned && work_q[WIDTH-1]) ? -work_q : work_q;
        absB     = (isSigned && oper_q[WIDTH-1]) ? -oper_q : oper_q;
        lastCnt  = CNT_W'(WIDTH - 1);
        product  = {acc_q, work_q};
`ifdef MULDIV_EARLY_OUT_EN
        if (early_q) begin
            lastCnt = CNT_W'(WIDTH/2 - 1);
            product = {acc_q, work_q} >> (WIDTH/2);
        end
`endif
        prodFixed = neg_res_q ? -product : product;
    end

    // Next-state logic for the sequencer FSM and its datapath registers
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        work_d    = work_q;
        oper_d    = oper_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef MULDIV_EARLY_OUT_EN
        early_d   = early_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    work_d  = a;
                    oper_d  = b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                cnt_d     = '0;
                acc_d     = '0;
                neg_res_d = isSigned & (work_q[WIDTH-1] ^ oper_q[WIDTH-1]);
                neg_rem_d = isSigned & work_q[WIDTH-1];
`ifdef MULDIV_EARLY_OUT_EN
                early_d   = 1'b0;
`endif
                if (isDiv) begin
                    work_d = absA;
                    oper_d = absB;
                    if (oper_q == '0) begin
                        hi_d    = work_q;
                        lo_d    = '1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ITER;
                    end
                end else begin
                    work_d  = absB;
                    oper_d  = absA;
`ifdef MULDIV_EARLY_OUT_EN
                    early_d = (absB[WIDTH-1:WIDTH/2] == '0);
`endif
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                acc_d  = stepAcc;
                work_d = stepWork;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == lastCnt) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (isDiv) begin
                    hi_d = neg_rem_q ? -acc_q : acc_q;
                    lo_d = neg_res_q ? -work_q : work_q;
                end else begin
                    hi_d = prodFixed[2*WIDTH-1:WIDTH];
                    lo_d = prodFixed[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            work_q    <= '0;
            oper_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef MULDIV_EARLY_OUT_EN
            early_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            work_q    <= work_d;
            oper_q    <= oper_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`ifdef MULDIV_EARLY_OUT_EN
            early_q   <= early_d;
`endif
        end
    end

    // Status and result outputs decode straight from registered state
    always_comb begin
        busy = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
        done = (state_q == S_DONE);
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int totalChecks = 0;
    int badChecks   = 0;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected hi/lo and cycles from start to done, from integer arithmetic
    function automatic void refModel(input logic [1:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                                     output logic [31:0] expHi, output logic [31:0] expLo, output int expLat);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        longint      q;
        longint      r;
        sa = longint'($signed(aIn));
        sb = longint'($signed(bIn));
        ua = {32'd0, aIn};
        ub = {32'd0, bIn};
        expLat = 35;
        if (opIn == OP_MULT || opIn == OP_MULTU) begin
            if (opIn == OP_MULT) p = 64'(sa * sb);
            else                 p = ua * ub;
            expHi = p[63:32];
            expLo = p[31:0];
`ifdef MULDIV_EARLY_OUT_EN
            if (opIn == OP_MULT) begin
                if ((sb < 0 ? -sb : sb) < 65536) expLat = 19;
            end else begin
                if (ub < 65536) expLat = 19;
            end
`endif
        end else if (bIn == 32'd0) begin
            expHi  = aIn;
            expLo  = 32'hFFFF_FFFF;
            expLat = 2;
        end else if (opIn == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
            expHi = 32'(r);
            expLo = 32'(q);
        end else begin
            p = ua / ub;
            expLo = p[31:0];
            p = ua % ub;
            expHi = p[31:0];
        end
    endfunction

    // Issue one op from IDLE, follow it to done and check timing and results
    task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                                 input bit intrude, input bit pokeDone);
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expLat;
        int          k;
        refModel(opIn, aIn, bIn, expHi, expLo, expLat);
        op = opIn;
        a = aIn;
        b = bIn;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 2'($urandom);
        k = 1;
        while (!done && k < 60) begin
            checkOutput("busy_during_op", 64'(busy), 64'd1);
            start = (intrude && k == 5);
            if (start) begin
                a = $urandom;
                b = $urandom;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        checkOutput("done_seen", 64'(done), 64'd1);
        checkOutput("latency", 64'(k), 64'(expLat));
        checkOutput("busy_at_done", 64'(busy), 64'd0);
        checkOutput("hi", 64'(hi), 64'(expHi));
        checkOutput("lo", 64'(lo), 64'(expLo));
        if (pokeDone) begin
            start = 1'b1;
            op = OP_MULTU;
            a = $urandom;
            b = $urandom;
        end
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("done_pulse_width", 64'(done), 64'd0);
        checkOutput("idle_after_done", 64'(busy), 64'd0);
        checkOutput("hi_hold", 64'(hi), 64'(expHi));
        checkOutput("lo_hold", 64'(lo), 64'(expLo));
    endtask

    logic [1:0]  opR;
    logic [31:0] aR;
    logic [31:0] bR;

    // Directed cases, a mid-operation reset, then randomized operations
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op = OP_MULT;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        applyStimulus(OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
        applyStimulus(OP_DIVU, 32'd5, 32'd0, 1'b0, 1'b0);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(OP_DIVU, 32'd1000, 32'd33, 1'b1, 1'b1);
        applyStimulus(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);

        op = OP_MULTU;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midop_reset_busy", 64'(busy), 64'd0);
        checkOutput("midop_reset_done", 64'(done), 64'd0);
        checkOutput("midop_reset_hi", 64'(hi), 64'd0);
        checkOutput("midop_reset_lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("after_release_busy", 64'(busy), 64'd0);
        applyStimulus(OP_MULTU, 32'd6, 32'd7, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            opR = 2'($urandom_range(0, 3));
            aR = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       bR = 32'd0;
                1:       bR = 32'($urandom_range(1, 65535));
                2:       bR = 32'd0 - 32'($urandom_range(1, 100));
                default: bR = 32'($urandom);
            endcase
            applyStimulus(opR, aR, bR, (i % 5) == 1, (i % 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
